// File: rtl/axi_rd_master_if.sv
// AXI3 read-master engine: splits a linear block read into INCR bursts
// (at most 16 beats, one outstanding) and streams R data to a consumer.
// Optional feature macro: AXI_RD_MASTER_4K_SPLIT_EN -- when defined, bursts
// are additionally clipped at 4 KB address boundaries.
module axi_rd_master_if #(
    parameter int unsigned A     = 32,
    parameter int unsigned I     = 4,
    parameter int unsigned L     = 4,
    parameter int unsigned D     = 64,
    parameter int unsigned M     = D / 8,
    parameter int unsigned SIZE  = 3,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned RD_ID = 0
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [A-1:0]     cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             done,
    output logic             err,
    output logic [I-1:0]     ARID,
    output logic [A-1:0]     ARADDR,
    output logic [L-1:0]     ARLEN,
    output logic [2:0]       ARSIZE,
    output logic [1:0]       ARBURST,
    output logic [1:0]       ARLOCK,
    output logic [3:0]       ARCACHE,
    output logic [2:0]       ARPROT,
    output logic             ARVALID,
    input  logic             ARREADY,
    input  logic [I-1:0]     RID,
    input  logic [D-1:0]     RDATA,
    input  logic [1:0]       RRESP,
    input  logic             RLAST,
    input  logic             RVALID,
    output logic             RREADY,
    output logic             dout_valid,
    output logic [D-1:0]     dout_data,
    output logic             dout_last,
    input  logic             dout_ready
);

    localparam int unsigned MAXB = 2 ** L;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t           state_q;
    logic [A-1:0]     araddr_q;
    logic [L-1:0]     arlen_q;
    logic [L-1:0]     beat_q;
    logic [LEN_W-1:0] rem_q;
    logic             arvalid_q;
    logic             cmd_ready_q;
    logic             done_q;
    logic             err_q;

    logic [A-1:0]     addr_aligned;
    logic [LEN_W-1:0] src_rem;
    logic [LEN_W-1:0] n_beats;
    logic [L-1:0]     arlen_d;
    logic             r_hs;
    logic             last_beat;
    logic             beat_err;
`ifdef AXI_RD_MASTER_4K_SPLIT_EN
    logic [11:0]      src_addr;
    logic [12:0]      to_bnd;
`endif

    assign addr_aligned = cmd_addr & ~(A'(M) - 1'b1);
    assign r_hs         = (state_q == DATA) && RVALID && dout_ready;
    assign last_beat    = (beat_q == arlen_q);
    assign beat_err     = (RRESP != 2'b00) || (RLAST != last_beat) || (RID != I'(RD_ID));

    // Length of the next burst, from the command (IDLE) or from the running
    // address/remaining registers (end of a burst in DATA).
    always_comb begin
        src_rem = (state_q == IDLE) ? cmd_len : rem_q;
        n_beats = (src_rem > LEN_W'(MAXB)) ? LEN_W'(MAXB) : src_rem;
`ifdef AXI_RD_MASTER_4K_SPLIT_EN
        src_addr = (state_q == IDLE) ? addr_aligned[11:0] : araddr_q[11:0];
        to_bnd   = (13'h1000 - {1'b0, src_addr}) >> SIZE;
        if (LEN_W'(to_bnd) < n_beats) begin
            n_beats = LEN_W'(to_bnd);
        end
`endif
        arlen_d = L'(n_beats - 1'b1);
    end

    // Control FSM; all handshake-facing control outputs are registered here.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arlen_q     <= '0;
            beat_q      <= '0;
            rem_q       <= '0;
            arvalid_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        err_q       <= 1'b0;
                        if (cmd_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            araddr_q  <= addr_aligned;
                            rem_q     <= cmd_len;
                            arlen_q   <= arlen_d;
                            arvalid_q <= 1'b1;
                            state_q   <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        // araddr_q now tracks the next burst start; ARVALID is low
                        arvalid_q <= 1'b0;
                        araddr_q  <= araddr_q + (A'({1'b0, arlen_q}) + 1'b1) * A'(M);
                        rem_q     <= rem_q - (LEN_W'({1'b0, arlen_q}) + 1'b1);
                        beat_q    <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_err) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            if (rem_q != '0) begin
                                arlen_q   <= arlen_d;
                                arvalid_q <= 1'b1;
                                state_q   <= ADDR;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign ARID       = I'(RD_ID);
    assign ARADDR     = araddr_q;
    assign ARLEN      = arlen_q;
    assign ARSIZE     = 3'(SIZE);
    assign ARBURST    = 2'b01;
    assign ARLOCK     = 2'b00;
    assign ARCACHE    = 4'b0011;
    assign ARPROT     = 3'b000;
    assign ARVALID    = arvalid_q;
    assign RREADY     = (state_q == DATA) && dout_ready;
    assign dout_valid = (state_q == DATA) && RVALID;
    assign dout_data  = RDATA;
    assign dout_last  = dout_valid && last_beat && (rem_q == '0);

endmodule

// File: doc/axi_rd_master_if.md
# axi_rd_master_if

AXI3 read-master engine that sits on the initiator side of the DSP memory AXI slave interface: it fetches a linear block of `cmd_len` bus words starting at `cmd_addr` for a DMA read channel. Each command is split into INCR bursts of up to 16 beats, with one burst outstanding at a time. R-channel data streams to a local consumer under backpressure. Completion and error status are reported per command.

## Interface
- `A`, 32, address width
- `I`, 4, ID width
- `L`, 4, AxLEN width (AXI3)
- `D`, 64, data width
- `M`, D/8, bytes per beat
- `SIZE`, 3, log2(M); driven on ARSIZE
- `LEN_W`, 16, width of command beat count
- `RD_ID`, 0, constant ARID value

- `ACLK` in 1 clock
- `ARESET` in 1 asynchronous, active-high reset
- `cmd_valid` in 1 command request
- `cmd_ready` out 1 engine idle, accepts command
- `cmd_addr` in A start byte address; low SIZE bits ignored
- `cmd_len` in LEN_W total beats; 0 = no-op
- `done` out 1 one-cycle pulse, command finished
- `err` out 1 status of last command, valid with `done`, held until next accept
- `ARID` out I, `ARADDR` out A, `ARLEN` out L, `ARSIZE` out 3, `ARBURST` out 2, `ARLOCK` out 2, `ARCACHE` out 4, `ARPROT` out 3, `ARVALID` out 1, `ARREADY` in 1: AXI3 read address channel
- `RID` in I, `RDATA` in D, `RRESP` in 2, `RLAST` in 1, `RVALID` in 1, `RREADY` out 1: AXI3 read data channel
- `dout_valid` out 1, `dout_data` out D, `dout_last` out 1 (final beat of command), `dout_ready` in 1: consumer stream

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: `cmd_ready`=1.
  - `cmd_valid` with `cmd_len`≠0: latch addr (low SIZE bits zeroed) and remaining=`cmd_len`, clear err, go to ADDR.
  - `cmd_len`=0: go to DONE directly, err=0.
- ADDR: `ARVALID`=1.
  - ARADDR/ARLEN are registered and stable until `ARREADY`.
  - Burst beats n = min(16, remaining, beats to next 4 KB boundary).
  - Beats to boundary = (4096 − addr[11:0]) >> SIZE.
  - ARLEN = n−1.
  - Fixed fields: ARBURST=01 (INCR), ARSIZE=SIZE, ARLOCK=0, ARCACHE=0011, ARPROT=000, ARID=RD_ID.
  - On handshake: addr += n<<SIZE, remaining −= n, beat counter = 0, go to DATA.
- DATA:
  - `dout_valid`=`RVALID`; `RREADY`=`dout_ready`; `dout_data`=`RDATA` (combinational pass-through).
  - Each beat handshake increments the beat counter.
  - Error sets err (sticky) on any of: RRESP≠00; RLAST=1 on a beat other than the ARLEN-th; RLAST=0 on the ARLEN-th beat; RID≠RD_ID.
  - The ARLEN-th beat ends the burst: go to ADDR if remaining≠0, else DONE.
  - `dout_last`=1 only on the final beat with remaining=0.
- DONE: `done`=1 for one cycle, then IDLE.
- An error never aborts: all requested bursts are issued and drained.
- Reset values: state IDLE; `cmd_ready`=1; `ARVALID`=0; `RREADY`=0; `dout_valid`=0; `done`=0; `err`=0; ARADDR/ARLEN=0.
- Reset mid-command abandons the transfer immediately; no further AR is issued.

## Timing
- Command accept to ARVALID high: 1 cycle (registered).
- ARVALID stays high until ARREADY; AR fields never change while ARVALID=1 and ARREADY=0.
- The last R beat of a burst (non-final) is followed by ARVALID of the next burst on the next cycle.
- Minimum per-burst overhead: 1 AR cycle. Zero-wait 16-beat burst = 17 cycles.
- `done` asserts in the cycle after the final R handshake.
- `cmd_ready` rises the cycle after `done`. Back-to-back commands are accepted at 1 per (done+1) cycle.
- A zero-length command produces `done` 1 cycle after accept.
- `RREADY` is 0 outside DATA. R beats arriving in IDLE/ADDR are not accepted.
- remaining and addr arithmetic is unsigned modulo width. Address wrap past 2^A is not detected.

## Configuration
- `AXI_RD_MASTER_4K_SPLIT_EN` defined: burst length is also limited by the 4 KB boundary term.
- Undefined: n = min(16, remaining). The boundary term is removed and the caller guarantees no 4 KB crossing.

## Test plan
- cmd_addr=0x1000, cmd_len=16, zero-wait slave, dout_ready=1 -> one AR with ARLEN=15 at 0x1000; 16 beats out with dout_last on beat 16; done 1 cycle later; err=0.
- cmd_addr=0x2000, cmd_len=40 -> three bursts: ARLEN 15/15/7 at 0x2000/0x2080/0x2100; 40 beats total.
- 4K_SPLIT_EN set, cmd_addr=0x0FC0, cmd_len=16 -> bursts ARLEN 7 at 0x0FC0, then ARLEN 7 at 0x1000. Macro unset -> single ARLEN 15.
- ARREADY held low 5 cycles, then dout_ready toggling 1/0 -> AR fields stable throughout; no beat dropped or duplicated; order preserved.
- RRESP=10 on beat 3 of a cmd_len=8 read -> all 8 beats delivered; done with err=1. Next cmd_len=0 command -> done after 1 cycle with err=0.
- ARESET asserted during DATA of burst 2 -> next cycle ARVALID=0, RREADY=0, cmd_ready=1; a new command then runs normally.
